// File: rtl/display_scan_controller_if.sv
// Processor-side load handshake and decoder/digit drive bundle for the scan controller.
// The processor (master) requests a display value; the controller (slave) drives the digits.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_en;
  logic                    load_ack;
  logic [3:0]              digit_code;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    blank;

  modport master (
    output load, value, lz_en,
    input  load_ack, digit_code, digit_sel, blank
  );

  modport slave (
    input  load, value, lz_en,
    output load_ack, digit_code, digit_sel, blank
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one hex decoder,
// with ghost-blanking gaps, frame-aligned value swap and leading-zero suppression.
module display_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 500
) (
  input logic                    clock,
  input logic                    reset,
  display_scan_controller_if.slave bus
);
  localparam int VW    = 4 * NUM_DIGITS;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX  = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW    = $clog2(CMAX) + 1;

  localparam logic [CW-1:0]         ON_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

  localparam logic [0:0] ST_ON  = 1'b0;
  localparam logic [0:0] ST_GAP = 1'b1;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 1 || GAP_CYCLES < 1) begin : g_bad_param
    $error("display_scan_controller: illegal parameter set");
  end

  logic [0:0]    state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [VW-1:0] shadow, shadow_n;
  logic [VW-1:0] active, active_n;
  logic          pending, pending_n;
  logic          apply;

  logic                  load_ack_q, load_ack_n;
  logic [3:0]            code_q, code_n;
  logic [NUM_DIGITS-1:0] sel_q, sel_n;
  logic                  blank_q, blank_n;

  // Phase sequencing and the frame-aligned shadow -> active swap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    apply   = 1'b0;
    if (state == ST_ON) begin
      if (cnt == ON_LAST) begin
        state_n = ST_GAP;
        cnt_n   = '0;
      end
    end else if (cnt == GAP_LAST) begin
      state_n = ST_ON;
      cnt_n   = '0;
      if (idx == IDX_LAST) begin
        idx_n = '0;
        apply = pending;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
    active_n  = apply ? shadow : active;
    // A load landing on the apply edge refills the shadow and stays pending.
    shadow_n  = bus.load ? bus.value : shadow;
    pending_n = bus.load | (pending & ~apply);
  end

  // hi_zero[i]: nibbles NUM_DIGITS-1 down to i of the next active value are all zero.
  logic [NUM_DIGITS:0] hi_zero;
  assign hi_zero[NUM_DIGITS] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign hi_zero[i] = hi_zero[i+1] & (active_n[4*i +: 4] == 4'h0);
  end

  logic [3:0] nib;
  logic       supp;

  // Outputs are built from next-state values so they line up with state/idx.
  always_comb begin
    nib        = active_n[{idx_n, 2'b00} +: 4];
    supp       = bus.lz_en & (idx_n != '0) & hi_zero[idx_n];
    load_ack_n = apply;
    code_n     = code_q;
    sel_n      = '1;
    blank_n    = 1'b1;
    if (state_n == ST_ON) begin
      code_n = nib;
      if (!supp) begin
        sel_n   = ~(SEL_ONE << idx_n);
        blank_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_GAP;
      idx        <= IDX_LAST;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      load_ack_q <= 1'b0;
      code_q     <= 4'h0;
      sel_q      <= '1;
      blank_q    <= 1'b1;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      active     <= active_n;
      pending    <= pending_n;
      load_ack_q <= load_ack_n;
      code_q     <= code_n;
      sel_q      <= sel_n;
      blank_q    <= blank_n;
    end
  end

  assign bus.load_ack   = load_ack_q;
  assign bus.digit_code = code_q;
  assign bus.digit_sel  = sel_q;
  assign bus.blank      = blank_q;
endmodule
